// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode constants, fetch FSM state type and helpers.
package riscv_pkg;
  localparam int INSTR_W = 32;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  typedef enum logic [2:0] {S_ISSUE, S_WAIT, S_HOLD, S_DROP, S_FAULT} fetch_state_t;
  function automatic logic is_waiting(fetch_state_t s);
    return s inside {S_WAIT, S_DROP};
  endfunction
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: counts cycles spent waiting for mem_ack and flags expiry at WAIT_MAX.
module fetch_timeout_ctr #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat;
  // Saturates so repeated redirects inside S_DROP cannot wrap the count.
  assign sat       = cnt_q >= CW'(WAIT_MAX - 1);
  assign expired_o = enable_i && sat;
  always_comb cnt_d = clear_i ? '0 : (enable_i && !sat) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, req/ack instruction fetch into IR, redirect handling and sticky fault.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              WAIT_MAX = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               mem_req,
  output logic [XLEN-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [6:0]         ir_opcode,
  output logic [4:0]         ir_rd,
  output logic [4:0]         ir_rs1,
  output logic [4:0]         ir_rs2,
  output logic [XLEN-1:0]    ir_pc,
  output logic               fault
);
  fetch_state_t       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d, ir_pc_q, ir_pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               live_q, issued, redir_bad, accept, expired, tmo_clear, tmo_en;
  // live_q keeps mem_req low while reset is held even though the state is S_ISSUE.
  assign issued    = state_q == S_ISSUE && live_q;
  assign redir_bad = redirect && |redirect_pc[1:0];
  assign accept    = state_q == S_WAIT && mem_ack && !redirect;
  assign tmo_en    = is_waiting(state_q) && !mem_ack;
  assign tmo_clear = is_waiting(state_d) && state_d != state_q;
  fetch_timeout_ctr #(.WAIT_MAX(WAIT_MAX)) u_tmo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (tmo_clear),
    .enable_i (tmo_en),
    .expired_o(expired)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_ISSUE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ir_pc_q <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      live_q  <= 1'b1;
    end
  // A redirect goes to S_DROP only while a request is still outstanding after this cycle.
  always_comb begin
    state_d = state_q;
    if (state_q != S_FAULT) begin
      if (redir_bad)     state_d = S_FAULT;
      else if (redirect) state_d = (issued || (is_waiting(state_q) && !mem_ack)) ? S_DROP : S_ISSUE;
      else if (expired)  state_d = S_FAULT;
      else
        case (state_q)
          S_ISSUE: state_d = live_q   ? S_WAIT  : S_ISSUE;
          S_WAIT:  state_d = mem_ack  ? S_HOLD  : S_WAIT;
          S_HOLD:  state_d = ir_ready ? S_ISSUE : S_HOLD;
          S_DROP:  state_d = mem_ack  ? S_ISSUE : S_DROP;
          default: state_d = state_q;
        endcase
    end
  end
  always_comb begin
    pc_d    = state_q == S_FAULT ? pc_q
            : (redirect && !redir_bad) ? redirect_pc
            : accept ? pc_q + XLEN'(4) : pc_q;
    ir_d    = accept ? mem_rdata : ir_q;
    ir_pc_d = accept ? pc_q : ir_pc_q;
  end
  always_comb begin
    mem_req   = issued;
    mem_addr  = pc_q;
    ir_valid  = state_q == S_HOLD;
    fault     = state_q == S_FAULT;
    ir_instr  = ir_q;
    ir_opcode = ir_q[6:0];
    ir_rd     = ir_q[11:7];
    ir_rs1    = ir_q[19:15];
    ir_rs2    = ir_q[24:20];
    ir_pc     = ir_pc_q;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized fetch/redirect traffic against a transaction-level model.
module tb_instr_fetch_unit;
  import riscv_pkg::*;
  localparam int XLEN = 64;
  localparam int WAIT_MAX = 16;
  logic clk = 0, reset_n = 0, mem_ack = 0, redirect = 0, ir_ready = 0;
  logic mem_req, ir_valid, fault;
  logic [XLEN-1:0] mem_addr, ir_pc, redirect_pc = '0;
  logic [31:0] mem_rdata = '0, ir_instr;
  logic [6:0] ir_opcode;
  logic [4:0] ir_rd, ir_rs1, ir_rs2;
  int total = 0, bad = 0;
  logic [XLEN-1:0] m_pc, m_ir_pc;
  logic [31:0] m_ir;
  logic [6:0] ops [4] = '{OP_ADDI, OP_BRANCH, OP_JALR, OP_LUI};

  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(64'h0), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_opcode(ir_opcode), .ir_rd(ir_rd), .ir_rs1(ir_rs1),
    .ir_rs2(ir_rs2), .ir_pc(ir_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (mem_req === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [XLEN-1:0] rand_target();
    return {32'($urandom), 32'($urandom)} & ~64'h3;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 3)]};
  endfunction

  task automatic hard_reset;
    reset_n = 0; mem_ack = 0; redirect = 0; ir_ready = 0;
    tick(); tick();
    reset_n = 1;
    m_pc = '0; m_ir = '0; m_ir_pc = '0;
  endtask

  task automatic test_reset;
    reset_n = 0;
    tick();
    total++;
    if ({mem_req, ir_valid, fault} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got req/valid/fault=%b exp=000", {mem_req, ir_valid, fault});
    end
    total++;
    if (mem_addr !== 64'h0 || ir_instr !== 32'h0 || ir_pc !== 64'h0) begin
      bad++; $display("FAIL reset_data got addr=%h ir=%h ir_pc=%h exp all zero", mem_addr, ir_instr, ir_pc);
    end
    reset_n = 1;
    tick();
  endtask

  task automatic test_basic;
    bit ok;
    wait_req(ok);
    total++;
    if (!ok || mem_addr !== 64'h0) begin
      bad++; $display("FAIL basic_req got ok=%0d addr=%h exp addr=0", ok, mem_addr);
    end
    tick();
    mem_ack = 1; mem_rdata = 32'h00500093;
    tick();
    mem_ack = 0;
    total++;
    if (ir_valid !== 1'b1 || ir_opcode !== 7'h13 || ir_rd !== 5'd1 || ir_pc !== 64'h0 || ir_instr !== 32'h00500093) begin
      bad++; $display("FAIL basic_ir got v=%b op=%h rd=%0d pc=%h ir=%h exp v=1 op=13 rd=1 pc=0 ir=00500093",
                      ir_valid, ir_opcode, ir_rd, ir_pc, ir_instr);
    end
    ir_ready = 1;
    tick();
    ir_ready = 0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h4) begin
      bad++; $display("FAIL basic_next got req=%b addr=%h exp req=1 addr=4", mem_req, mem_addr);
    end
  endtask

  task automatic test_hold_stall;
    tick();
    mem_ack = 1; mem_rdata = 32'h00A00113;
    tick();
    mem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (ir_valid !== 1'b1 || mem_req !== 1'b0 || ir_instr !== 32'h00A00113 || ir_pc !== 64'h4) begin
        bad++; $display("FAIL hold_stall[%0d] got v=%b req=%b ir=%h pc=%h exp v=1 req=0 ir=00a00113 pc=4",
                        i, ir_valid, mem_req, ir_instr, ir_pc);
      end
      tick();
    end
    ir_ready = 1;
    tick();
    ir_ready = 0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8 || ir_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got req=%b addr=%h v=%b exp req=1 addr=8 v=0", mem_req, mem_addr, ir_valid);
    end
  endtask

  task automatic test_redirect_wait;
    tick();
    redirect = 1; redirect_pc = 64'h100;
    tick();
    redirect = 0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (mem_req !== 1'b0 || ir_valid !== 1'b0) begin
        bad++; $display("FAIL drop_idle[%0d] got req=%b v=%b exp 0 0", i, mem_req, ir_valid);
      end
      tick();
    end
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h100 || ir_instr !== 32'h00A00113 || ir_valid !== 1'b0) begin
      bad++; $display("FAIL redirect_wait got req=%b addr=%h ir=%h v=%b exp req=1 addr=100 ir=00a00113 v=0",
                      mem_req, mem_addr, ir_instr, ir_valid);
    end
  endtask

  task automatic test_redirect_ack;
    tick();
    redirect = 1; redirect_pc = 64'h200; mem_ack = 1; mem_rdata = 32'h12345678;
    tick();
    redirect = 0; mem_ack = 0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h200 || ir_instr !== 32'h00A00113 || ir_pc !== 64'h4 || ir_valid !== 1'b0) begin
      bad++; $display("FAIL redirect_ack got req=%b addr=%h ir=%h pc=%h v=%b exp req=1 addr=200 ir=00a00113 pc=4 v=0",
                      mem_req, mem_addr, ir_instr, ir_pc, ir_valid);
    end
    m_pc = 64'h200; m_ir = 32'h00A00113; m_ir_pc = 64'h4;
  endtask

  task automatic test_wrap;
    bit ok;
    logic [31:0] w;
    tick();
    mem_ack = 1; mem_rdata = 32'h00000037;
    tick();
    mem_ack = 0;
    redirect = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; ir_ready = 1;
    tick();
    redirect = 0; ir_ready = 0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC || ir_valid !== 1'b0) begin
      bad++; $display("FAIL wrap_redirect got req=%b addr=%h v=%b exp req=1 addr=fffffffffffffffc v=0",
                      mem_req, mem_addr, ir_valid);
    end
    w = rand_word();
    tick();
    mem_ack = 1; mem_rdata = w;
    tick();
    mem_ack = 0;
    total++;
    if (ir_pc !== 64'hFFFF_FFFF_FFFF_FFFC || ir_instr !== w) begin
      bad++; $display("FAIL wrap_ir got pc=%h ir=%h exp pc=fffffffffffffffc ir=%h", ir_pc, ir_instr, w);
    end
    ir_ready = 1;
    tick();
    ir_ready = 0;
    wait_req(ok);
    total++;
    if (!ok || mem_addr !== 64'h0) begin
      bad++; $display("FAIL wrap_pc got ok=%0d addr=%h exp addr=0", ok, mem_addr);
    end
    m_pc = 64'h0; m_ir = w; m_ir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
  endtask

  task automatic test_random;
    bit ok;
    int kind;
    logic [31:0] w;
    logic [XLEN-1:0] tgt;
    for (int it = 0; it < 80; it++) begin
      wait_req(ok);
      total++;
      if (!ok || mem_addr !== m_pc || ir_instr !== m_ir || ir_pc !== m_ir_pc || fault !== 1'b0) begin
        bad++; $display("FAIL rand_req[%0d] got ok=%0d addr=%h ir=%h irpc=%h f=%b exp addr=%h ir=%h irpc=%h f=0",
                        it, ok, mem_addr, ir_instr, ir_pc, fault, m_pc, m_ir, m_ir_pc);
      end
      kind = $urandom_range(0, 3);
      tick();
      if (kind <= 1) begin
        repeat ($urandom_range(0, 3)) tick();
        w = rand_word();
        mem_ack = 1; mem_rdata = w;
        tick();
        mem_ack = 0;
        m_ir = w; m_ir_pc = m_pc; m_pc = m_pc + 64'd4;
        total++;
        if (ir_valid !== 1'b1 || ir_instr !== m_ir || ir_opcode !== m_ir[6:0] || ir_rd !== m_ir[11:7] ||
            ir_rs1 !== m_ir[19:15] || ir_rs2 !== m_ir[24:20] || ir_pc !== m_ir_pc) begin
          bad++; $display("FAIL rand_ir[%0d] got v=%b ir=%h op=%h rd=%0d rs1=%0d rs2=%0d pc=%h exp ir=%h pc=%h",
                          it, ir_valid, ir_instr, ir_opcode, ir_rd, ir_rs1, ir_rs2, ir_pc, m_ir, m_ir_pc);
        end
        repeat ($urandom_range(0, 3)) tick();
        if (kind == 1) begin
          tgt = rand_target();
          redirect = 1; redirect_pc = tgt; ir_ready = 1'($urandom_range(0, 1));
          tick();
          redirect = 0; ir_ready = 0;
          m_pc = tgt;
          total++;
          if (ir_valid !== 1'b0) begin
            bad++; $display("FAIL rand_hold_redirect[%0d] got v=%b exp v=0", it, ir_valid);
          end
        end else begin
          ir_ready = 1;
          tick();
          ir_ready = 0;
        end
      end else if (kind == 2) begin
        repeat ($urandom_range(0, 2)) tick();
        tgt = rand_target();
        redirect = 1; redirect_pc = tgt;
        tick();
        redirect = 0;
        m_pc = tgt;
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(0, 2)) tick();
          tgt = rand_target();
          redirect = 1; redirect_pc = tgt;
          tick();
          redirect = 0;
          m_pc = tgt;
        end
        repeat ($urandom_range(0, 2)) tick();
        mem_ack = 1; mem_rdata = $urandom;
        tick();
        mem_ack = 0;
      end else begin
        repeat ($urandom_range(0, 3)) tick();
        tgt = rand_target();
        redirect = 1; redirect_pc = tgt; mem_ack = 1; mem_rdata = $urandom;
        tick();
        redirect = 0; mem_ack = 0;
        m_pc = tgt;
      end
    end
  endtask

  task automatic test_misaligned;
    bit ok;
    logic [31:0] w;
    wait_req(ok);
    w = rand_word();
    tick();
    mem_ack = 1; mem_rdata = w;
    tick();
    mem_ack = 0;
    m_ir = w; m_pc = m_pc + 64'd4;
    redirect = 1; redirect_pc = 64'h102;
    tick();
    redirect = 0;
    total++;
    if (fault !== 1'b1 || mem_req !== 1'b0 || ir_valid !== 1'b0 || mem_addr !== m_pc) begin
      bad++; $display("FAIL misalign got f=%b req=%b v=%b addr=%h exp f=1 req=0 v=0 addr=%h",
                      fault, mem_req, ir_valid, mem_addr, m_pc);
    end
    for (int i = 0; i < 4; i++) begin
      redirect = 1; redirect_pc = 64'h300; mem_ack = 1'(i % 2); ir_ready = 1;
      tick();
      total++;
      if (fault !== 1'b1 || mem_req !== 1'b0 || ir_valid !== 1'b0 || ir_instr !== m_ir || mem_addr !== m_pc) begin
        bad++; $display("FAIL fault_sticky[%0d] got f=%b req=%b v=%b ir=%h addr=%h exp f=1 req=0 v=0 ir=%h addr=%h",
                        i, fault, mem_req, ir_valid, ir_instr, mem_addr, m_ir, m_pc);
      end
    end
    redirect = 0; mem_ack = 0; ir_ready = 0;
    reset_n = 0;
    #1;
    total++;
    if (fault !== 1'b0 || mem_addr !== 64'h0) begin
      bad++; $display("FAIL fault_reset got f=%b addr=%h exp f=0 addr=0", fault, mem_addr);
    end
    hard_reset();
  endtask

  task automatic test_timeout;
    bit ok;
    wait_req(ok);
    total++;
    if (!ok || mem_addr !== 64'h0) begin
      bad++; $display("FAIL timeout_req got ok=%0d addr=%h exp addr=0", ok, mem_addr);
    end
    tick();
    for (int k = 1; k <= WAIT_MAX; k++) begin
      tick();
      total++;
      if (fault !== (k == WAIT_MAX) || mem_req !== 1'b0) begin
        bad++; $display("FAIL timeout[%0d] got f=%b req=%b exp f=%b req=0", k, fault, mem_req, k == WAIT_MAX);
      end
    end
    hard_reset();
  endtask

  task automatic test_async_reset;
    bit ok;
    logic [31:0] w;
    wait_req(ok);
    tick();
    mem_ack = 1; mem_rdata = 32'h0FF00093;
    tick();
    mem_ack = 0; ir_ready = 1;
    tick();
    ir_ready = 0;
    tick();
    #2 reset_n = 0;
    #1;
    total++;
    if ({mem_req, ir_valid, fault} !== 3'b000 || mem_addr !== 64'h0 || ir_instr !== 32'h0 || ir_pc !== 64'h0) begin
      bad++; $display("FAIL async_reset got req=%b v=%b f=%b addr=%h ir=%h pc=%h exp all zero",
                      mem_req, ir_valid, fault, mem_addr, ir_instr, ir_pc);
    end
    tick();
    reset_n = 1; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h0 || ir_instr !== 32'h0 || ir_valid !== 1'b0) begin
      bad++; $display("FAIL late_ack got req=%b addr=%h ir=%h v=%b exp req=1 addr=0 ir=0 v=0",
                      mem_req, mem_addr, ir_instr, ir_valid);
    end
    w = rand_word();
    tick();
    mem_ack = 1; mem_rdata = w;
    tick();
    mem_ack = 0;
    total++;
    if (ir_valid !== 1'b1 || ir_instr !== w || ir_pc !== 64'h0) begin
      bad++; $display("FAIL post_reset_fetch got v=%b ir=%h pc=%h exp v=1 ir=%h pc=0", ir_valid, ir_instr, ir_pc, w);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_random();
    test_misaligned();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
